// File: rtl/memory_access_module.sv
// MEM stage + MEM/WB register.
// Turns EX/MEM control into byte-lane data-memory requests over a req/ack
// handshake and holds the pipeline while the request is outstanding.
// Load data is returned right-aligned and zero-filled; the write-back code
// tells the next stage whether it still needs to sign-extend.

`ifndef DATA_FROM_ALU
`define DATA_FROM_ALU 2'b00
`endif
`ifndef DATA_FROM_MEM
`define DATA_FROM_MEM 2'b01
`endif
`ifndef DATA_SIGN_BYT
`define DATA_SIGN_BYT 2'b10
`endif
`ifndef DATA_SIGN_HAL
`define DATA_SIGN_HAL 2'b11
`endif

module memory_access_module #(
    parameter int NB_BITS = 32,
    parameter int NB_REG  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_BITS-1:0] i_alu_data,
    input  logic [NB_BITS-1:0] i_store_data,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [1:0]         i_size,
    input  logic               i_unsigned,
    input  logic [1:0]         i_mux_mem_to_reg,
    input  logic               i_reg_write,
    input  logic [NB_REG-1:0]  i_rd_addr,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    output logic [NB_BITS-1:0] o_dmem_addr,
    output logic [NB_BITS-1:0] o_dmem_wdata,
    output logic [3:0]         o_dmem_be,
    input  logic               i_dmem_ack,
    input  logic [NB_BITS-1:0] i_dmem_rdata,
    output logic               o_stall,
    output logic               o_valid,
    output logic [NB_BITS-1:0] o_mem_data,
    output logic [NB_BITS-1:0] o_alu_data,
    output logic [1:0]         o_mux_mem_to_reg,
    output logic               o_reg_write,
    output logic [NB_REG-1:0]  o_rd_addr,
    output logic               o_misaligned,
    output logic               o_bus_error
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;

    // fields of the outstanding access, needed again when it completes
    logic               ld_q;
    logic               rw_q;
    logic               uns_q;
    logic [1:0]         size_q;
    logic [1:0]         off_q;
    logic [1:0]         mux_q;
    logic [NB_REG-1:0]  rd_q;
    logic [NB_BITS-1:0] alu_q;

    logic [1:0]         off;
    logic               mem_op;
    logic               misaligned;
    logic               timeout_hit;
    logic [3:0]         st_be;
    logic [NB_BITS-1:0] st_wdata;
    logic [NB_BITS-1:0] shifted;
    logic [NB_BITS-1:0] ld_data;
    logic [1:0]         ld_code;

    assign off    = i_alu_data[1:0];
    assign mem_op = i_valid & (i_mem_read | i_mem_write);

    // alignment: bytes always fit, halves need bit 0 clear, words both bits
    always_comb begin
        misaligned = 1'b0;
        if (i_size == 2'd1)
            misaligned = off[0];
        else if (i_size != 2'd0)
            misaligned = |off;
    end

    // store lane steering: replicate the datum, select lanes with be
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = i_store_data;
        case (i_size)
            2'd0: begin
                st_be    = 4'b0001 << off;
                st_wdata = NB_BITS'({4{i_store_data[7:0]}});
            end
            2'd1: begin
                st_be    = off[1] ? 4'b1100 : 4'b0011;
                st_wdata = NB_BITS'({2{i_store_data[15:0]}});
            end
            default: ;
        endcase
    end

    // load alignment: shift the addressed lane to bit 0, zero-fill above it
    always_comb begin
        shifted = i_dmem_rdata >> {off_q, 3'b000};
        ld_data = shifted;
        ld_code = `DATA_FROM_MEM;
        case (size_q)
            2'd0: begin
                ld_data = NB_BITS'(shifted[7:0]);
                ld_code = uns_q ? `DATA_FROM_MEM : `DATA_SIGN_BYT;
            end
            2'd1: begin
                ld_data = NB_BITS'(shifted[15:0]);
                ld_code = uns_q ? `DATA_FROM_MEM : `DATA_SIGN_HAL;
            end
            default: ;
        endcase
    end

    assign timeout_hit = (state == S_WAIT) & ~i_dmem_ack & (cnt == CW'(TIMEOUT - 1));

    // hold upstream while a request is being launched or is still pending;
    // released in the completing cycle (ack or timeout) so EX/MEM advances
    assign o_stall = i_reset & ((state == S_IDLE) ? (mem_op & ~misaligned)
                                                  : ~(i_dmem_ack | timeout_hit));

    // access FSM, memory request registers and MEM/WB register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            ld_q             <= 1'b0;
            rw_q             <= 1'b0;
            uns_q            <= 1'b0;
            size_q           <= '0;
            off_q            <= '0;
            mux_q            <= '0;
            rd_q             <= '0;
            alu_q            <= '0;
            o_dmem_req       <= 1'b0;
            o_dmem_we        <= 1'b0;
            o_dmem_addr      <= '0;
            o_dmem_wdata     <= '0;
            o_dmem_be        <= '0;
            o_valid          <= 1'b0;
            o_mem_data       <= '0;
            o_alu_data       <= '0;
            o_mux_mem_to_reg <= '0;
            o_reg_write      <= 1'b0;
            o_rd_addr        <= '0;
            o_misaligned     <= 1'b0;
            o_bus_error      <= 1'b0;
        end else begin
            o_misaligned <= 1'b0;
            o_bus_error  <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_alu_data <= i_alu_data;
                    o_rd_addr  <= i_rd_addr;
                    o_mem_data <= '0;
                    if (mem_op && !misaligned) begin
                        state        <= S_WAIT;
                        cnt          <= '0;
                        o_dmem_req   <= 1'b1;
                        o_dmem_we    <= ~i_mem_read;
                        o_dmem_addr  <= {i_alu_data[NB_BITS-1:2], 2'b00};
                        o_dmem_wdata <= i_mem_read ? '0 : st_wdata;
                        o_dmem_be    <= i_mem_read ? 4'b1111 : st_be;
                        ld_q         <= i_mem_read;
                        rw_q         <= i_reg_write;
                        uns_q        <= i_unsigned;
                        size_q       <= i_size;
                        off_q        <= off;
                        mux_q        <= i_mux_mem_to_reg;
                        rd_q         <= i_rd_addr;
                        alu_q        <= i_alu_data;
                        o_valid      <= 1'b0;
                        o_reg_write  <= 1'b0;
                    end else if (mem_op) begin
                        o_valid          <= 1'b1;
                        o_reg_write      <= 1'b0;
                        o_misaligned     <= 1'b1;
                        o_mux_mem_to_reg <= i_mux_mem_to_reg;
                    end else begin
                        o_valid          <= i_valid;
                        o_reg_write      <= i_valid & i_reg_write;
                        o_mux_mem_to_reg <= i_mux_mem_to_reg;
                    end
                end
                S_WAIT: begin
                    if (i_dmem_ack) begin
                        state            <= S_IDLE;
                        o_dmem_req       <= 1'b0;
                        o_dmem_we        <= 1'b0;
                        o_valid          <= 1'b1;
                        o_reg_write      <= ld_q & rw_q;
                        o_mem_data       <= ld_q ? ld_data : '0;
                        o_mux_mem_to_reg <= ld_q ? ld_code : mux_q;
                        o_alu_data       <= alu_q;
                        o_rd_addr        <= rd_q;
                    end else if (timeout_hit) begin
                        state            <= S_IDLE;
                        o_dmem_req       <= 1'b0;
                        o_dmem_we        <= 1'b0;
                        o_bus_error      <= 1'b1;
                        o_valid          <= 1'b1;
                        o_reg_write      <= 1'b0;
                        o_mem_data       <= '0;
                        o_mux_mem_to_reg <= mux_q;
                        o_alu_data       <= alu_q;
                        o_rd_addr        <= rd_q;
                    end else begin
                        cnt         <= cnt + 1'b1;
                        o_valid     <= 1'b0;
                        o_reg_write <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_module.sv
// Bench for memory_access_module: a vector table drives single operations
// through a small memory responder; write-back results are predicted into a
// queue and matched when MEM/WB raises o_valid. Timeout and reset-abort
// sequences are written out by hand.
module tb_memory_access_module;

    localparam logic [1:0] FA = 2'b00;  // from ALU
    localparam logic [1:0] FM = 2'b01;  // from memory, no extension
    localparam logic [1:0] SB = 2'b10;  // sign-extend byte
    localparam logic [1:0] SH = 2'b11;  // sign-extend half

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_alu_data = '0;
    logic [31:0] i_store_data = '0;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic [1:0]  i_size = '0;
    logic        i_unsigned = 1'b0;
    logic [1:0]  i_mux_mem_to_reg = '0;
    logic        i_reg_write = 1'b0;
    logic [4:0]  i_rd_addr = '0;
    logic        i_dmem_ack = 1'b0;
    logic [31:0] i_dmem_rdata = '0;
    logic        o_dmem_req, o_dmem_we, o_stall, o_valid, o_reg_write;
    logic        o_misaligned, o_bus_error;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_mem_data, o_alu_data;
    logic [3:0]  o_dmem_be;
    logic [1:0]  o_mux_mem_to_reg;
    logic [4:0]  o_rd_addr;

    memory_access_module #(.NB_BITS(32), .NB_REG(5), .TIMEOUT(16)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid),
        .i_alu_data(i_alu_data), .i_store_data(i_store_data),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_size(i_size),
        .i_unsigned(i_unsigned), .i_mux_mem_to_reg(i_mux_mem_to_reg),
        .i_reg_write(i_reg_write), .i_rd_addr(i_rd_addr),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_stall(o_stall), .o_valid(o_valid), .o_mem_data(o_mem_data),
        .o_alu_data(o_alu_data), .o_mux_mem_to_reg(o_mux_mem_to_reg),
        .o_reg_write(o_reg_write), .o_rd_addr(o_rd_addr),
        .o_misaligned(o_misaligned), .o_bus_error(o_bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, sd;
        logic        rd_, wr;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  mux;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          dly;
        logic        mis;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic        chk_wd;
        logic [31:0] e_wdata;
        logic [31:0] e_mem;
        logic [1:0]  e_code;
        logic        e_rw;
    } vec_t;

    typedef struct {
        logic [31:0] alu, mem;
        logic [4:0]  rd;
        logic [1:0]  code;
        logic        rw, mis, berr;
        logic        chk_mem, chk_code, chk_ard;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            passes++;
    endtask

    function automatic vec_t mv(
        input logic [31:0] alu, input logic [31:0] sd, input logic rd_, input logic wr,
        input logic [1:0] size, input logic uns, input logic [1:0] mux, input logic rw,
        input logic [4:0] rd, input logic [31:0] rdata, input int dly, input logic mis,
        input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_be,
        input logic chk_wd, input logic [31:0] e_wdata, input logic [31:0] e_mem,
        input logic [1:0] e_code, input logic e_rw);
        vec_t v;
        v.alu = alu; v.sd = sd; v.rd_ = rd_; v.wr = wr; v.size = size; v.uns = uns;
        v.mux = mux; v.rw = rw; v.rd = rd; v.rdata = rdata; v.dly = dly; v.mis = mis;
        v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be; v.chk_wd = chk_wd;
        v.e_wdata = e_wdata; v.e_mem = e_mem; v.e_code = e_code; v.e_rw = e_rw;
        return v;
    endfunction

    // write-back monitor: every o_valid must match the oldest prediction
    always @(negedge clk) begin
        if (i_reset) begin
            if (o_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 64'(o_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_reg_write", 64'(o_reg_write), 64'(e.rw));
                    chk("wb_misaligned", 64'(o_misaligned), 64'(e.mis));
                    chk("wb_bus_error", 64'(o_bus_error), 64'(e.berr));
                    if (e.chk_ard) begin
                        chk("wb_alu_data", 64'(o_alu_data), 64'(e.alu));
                        chk("wb_rd_addr", 64'(o_rd_addr), 64'(e.rd));
                    end
                    if (e.chk_code) chk("wb_code", 64'(o_mux_mem_to_reg), 64'(e.code));
                    if (e.chk_mem) chk("wb_mem_data", 64'(o_mem_data), 64'(e.mem));
                end
            end else begin
                chk("pulse_without_valid", {62'd0, o_misaligned, o_bus_error}, 64'd0);
                chk("reg_write_without_valid", 64'(o_reg_write), 64'd0);
            end
        end
    end

    task automatic drive(input vec_t v);
        i_valid = 1'b1; i_alu_data = v.alu; i_store_data = v.sd;
        i_mem_read = v.rd_; i_mem_write = v.wr; i_size = v.size; i_unsigned = v.uns;
        i_mux_mem_to_reg = v.mux; i_reg_write = v.rw; i_rd_addr = v.rd;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic memop, acc, stable;
        int   stalls;
        exp_t e;
        memop = v.rd_ | v.wr;
        acc   = memop & ~v.mis;
        @(posedge clk); #1;
        drive(v);
        e.alu = v.alu; e.rd = v.rd; e.rw = v.e_rw; e.mem = v.e_mem; e.code = v.e_code;
        e.mis = v.mis; e.berr = 1'b0;
        e.chk_ard = ~v.mis; e.chk_code = ~v.mis; e.chk_mem = acc & v.rd_;
        sb.push_back(e);
        @(negedge clk);
        chk($sformatf("v%0d accept_stall", idx), 64'(o_stall), 64'(acc));
        if (acc) begin
            stalls = 1; stable = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("v%0d req", idx), 64'(o_dmem_req), 64'd1);
            chk($sformatf("v%0d addr", idx), 64'(o_dmem_addr), 64'(v.e_addr));
            chk($sformatf("v%0d we", idx), 64'(o_dmem_we), 64'(v.e_we));
            chk($sformatf("v%0d be", idx), 64'(o_dmem_be), 64'(v.e_be));
            if (v.chk_wd) chk($sformatf("v%0d wdata", idx), 64'(o_dmem_wdata), 64'(v.e_wdata));
            for (int k = 0; k <= v.dly; k++) begin
                i_dmem_ack   = (k == v.dly);
                i_dmem_rdata = (k == v.dly) ? v.rdata : 32'h0;
                @(negedge clk);
                if (o_stall) stalls++;
                if (!o_dmem_req || o_dmem_addr !== v.e_addr || o_dmem_be !== v.e_be ||
                    o_dmem_we !== v.e_we) stable = 1'b0;
                @(posedge clk); #1;
            end
            i_dmem_ack = 1'b0; i_dmem_rdata = '0; i_valid = 1'b0;
            chk($sformatf("v%0d stall_cycles", idx), 64'(stalls), 64'(v.dly + 1));
            chk($sformatf("v%0d req_stable", idx), 64'(stable), 64'd1);
            chk($sformatf("v%0d req_dropped", idx), 64'(o_dmem_req), 64'd0);
        end else begin
            @(posedge clk); #1;
            i_valid = 1'b0;
            chk($sformatf("v%0d no_req", idx), 64'(o_dmem_req), 64'd0);
        end
    endtask

    vec_t tbl[16];

    initial begin
        //          alu           sd            rd wr sz un mux rw rd  rdata         dly mis addr          we be       cw wdata         mem           code rw
        tbl[0]  = mv(32'h1234,    32'h0,        0, 0, 2, 0, FA, 1, 5,  32'h0,        0,  0, 32'h0,        0, 4'h0,    0, 32'h0,        32'h0,        FA, 1);
        tbl[1]  = mv(32'h103,     32'h0,        1, 0, 0, 0, FA, 1, 7,  32'h80AABBCC, 3,  0, 32'h100,      0, 4'hF,    0, 32'h0,        32'h80,       SB, 1);
        tbl[2]  = mv(32'h103,     32'h0,        1, 0, 0, 1, FA, 1, 8,  32'h80AABBCC, 3,  0, 32'h100,      0, 4'hF,    0, 32'h0,        32'h80,       FM, 1);
        tbl[3]  = mv(32'h202,     32'h0000BEEF, 0, 1, 1, 0, FA, 1, 9,  32'h0,        0,  0, 32'h200,      1, 4'b1100, 1, 32'hBEEFBEEF, 32'h0,        FA, 0);
        tbl[4]  = mv(32'h101,     32'h0,        1, 0, 2, 0, FA, 1, 3,  32'h0,        0,  1, 32'h0,        0, 4'h0,    0, 32'h0,        32'h0,        FA, 0);
        tbl[5]  = mv(32'h102,     32'h0,        1, 0, 1, 0, FA, 1, 10, 32'h1234ABCD, 1,  0, 32'h100,      0, 4'hF,    0, 32'h0,        32'h1234,     SH, 1);
        tbl[6]  = mv(32'h100,     32'h0,        1, 0, 1, 1, FA, 1, 11, 32'hFFFF8001, 2,  0, 32'h100,      0, 4'hF,    0, 32'h0,        32'h8001,     FM, 1);
        tbl[7]  = mv(32'h104,     32'h0,        1, 0, 2, 0, FA, 1, 12, 32'hDEADBEEF, 0,  0, 32'h104,      0, 4'hF,    0, 32'h0,        32'hDEADBEEF, FM, 1);
        tbl[8]  = mv(32'h301,     32'h123456A5, 0, 1, 0, 0, FA, 1, 13, 32'h0,        1,  0, 32'h300,      1, 4'b0010, 1, 32'hA5A5A5A5, 32'h0,        FA, 0);
        tbl[9]  = mv(32'h308,     32'hCAFEF00D, 0, 1, 2, 0, FA, 1, 14, 32'h0,        0,  0, 32'h308,      1, 4'b1111, 1, 32'hCAFEF00D, 32'h0,        FA, 0);
        tbl[10] = mv(32'h102,     32'h0,        1, 0, 0, 0, FA, 1, 15, 32'h11FE2233, 1,  0, 32'h100,      0, 4'hF,    0, 32'h0,        32'hFE,       SB, 1);
        tbl[11] = mv(32'h10,      32'hFFFFFFFF, 1, 1, 2, 0, FA, 1, 16, 32'h55,       1,  0, 32'h10,       0, 4'hF,    0, 32'h0,        32'h55,       FM, 1);
        tbl[12] = mv(32'h20,      32'h0,        1, 0, 3, 0, FA, 1, 17, 32'h01020304, 0,  0, 32'h20,       0, 4'hF,    0, 32'h0,        32'h01020304, FM, 1);
        tbl[13] = mv(32'h203,     32'h1111,     0, 1, 1, 0, FA, 1, 18, 32'h0,        0,  1, 32'h0,        0, 4'h0,    0, 32'h0,        32'h0,        FA, 0);
        tbl[14] = mv(32'h302,     32'h00000077, 0, 1, 0, 0, FA, 1, 19, 32'h0,        2,  0, 32'h300,      1, 4'b0100, 1, 32'h77777777, 32'h0,        FA, 0);
        tbl[15] = mv(32'hABCD,    32'h0,        0, 0, 2, 0, 2'b01, 0, 20, 32'h0,     0,  0, 32'h0,        0, 4'h0,    0, 32'h0,        32'h0,        2'b01, 0);

        // power-on reset
        #2 i_reset = 1'b0;
        #1;
        chk("reset_dmem", {o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr}, 64'd0);
        chk("reset_wdata_stall", {o_dmem_wdata, 31'd0, o_stall}, 64'd0);
        chk("reset_wb", {o_valid, o_reg_write, o_misaligned, o_bus_error, o_mux_mem_to_reg, o_rd_addr, o_alu_data}, 64'd0);
        chk("reset_mem_data", 64'(o_mem_data), 64'd0);
        #19 i_reset = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

        // an idle slot with i_valid low produces no write-back
        @(posedge clk); #1;
        i_valid = 1'b0; i_reg_write = 1'b1;
        @(posedge clk); #1;
        chk("invalid_valid", 64'(o_valid), 64'd0);
        chk("invalid_reg_write", 64'(o_reg_write), 64'd0);
        i_reg_write = 1'b0;

        // ack timeout: load with no ack
        begin
            exp_t e;
            int   reqc;
            vec_t v;
            v = tbl[7];
            v.alu = 32'h400;
            @(posedge clk); #1;
            drive(v);
            e = '{alu: 32'h0, mem: 32'h0, rd: 5'd0, code: 2'b00, rw: 1'b0, mis: 1'b0,
                  berr: 1'b1, chk_mem: 1'b0, chk_code: 1'b0, chk_ard: 1'b0};
            sb.push_back(e);
            @(posedge clk); #1;
            reqc = 0;
            while (o_dmem_req && reqc < 40) begin
                reqc++;
                @(posedge clk); #1;
            end
            i_valid = 1'b0;
            chk("timeout_req_cycles", 64'(reqc), 64'd16);
            chk("timeout_req_dropped", 64'(o_dmem_req), 64'd0);
            // a late ack in IDLE must be ignored
            @(posedge clk); #1;
            i_dmem_ack = 1'b1; i_dmem_rdata = 32'hFFFFFFFF;
            @(posedge clk); #1;
            i_dmem_ack = 1'b0; i_dmem_rdata = '0;
            chk("late_ack_no_req", 64'(o_dmem_req), 64'd0);
            chk("late_ack_no_valid", 64'(o_valid), 64'd0);
        end
        run_vec(tbl[0], 100);

        // reset in the middle of an outstanding access
        @(posedge clk); #1;
        drive(tbl[7]);
        @(posedge clk); #1;
        chk("midreset_req_before", 64'(o_dmem_req), 64'd1);
        @(posedge clk); #2;
        i_reset = 1'b0;
        #1;
        chk("midreset_req", 64'(o_dmem_req), 64'd0);
        chk("midreset_outs", {o_valid, o_stall, o_reg_write, o_dmem_we, o_dmem_be, o_dmem_addr}, 64'd0);
        i_valid = 1'b0;
        @(posedge clk); #1;
        i_reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_no_valid", 64'(o_valid), 64'd0);
        end
        run_vec(tbl[1], 101);
        run_vec(tbl[0], 102);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/memory_access_module.md
Name: memory_access_module

Overview:
MEM stage plus MEM/WB pipeline register. It sits directly upstream of the write-back mux and converts EX/MEM control into byte-lane-correct data-memory transactions. A req/ack handshake tolerates multi-cycle memory, and the stage stalls the pipeline while an access is outstanding. It delivers load data right-aligned, with the mem-to-reg code chosen so that write-back only has to sign-extend.

Parameters:
NB_BITS, 32, datapath and address width
NB_REG, 5, register-file address width
TIMEOUT, 16, max cycles waiting for i_dmem_ack before bus error (≥2)

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_valid  in  1  EX/MEM holds a valid instruction
i_alu_data  in  NB_BITS  ALU result / effective address
i_store_data  in  NB_BITS  rt value for stores
i_mem_read  in  1  load
i_mem_write  in  1  store
i_size  in  2  0=byte, 1=half, 2=word (3 treated as word)
i_unsigned  in  1  LBU/LHU
i_mux_mem_to_reg  in  2  write-back select for non-loads
i_reg_write  in  1  writes register file
i_rd_addr  in  NB_REG  destination register
o_dmem_req  out  1  memory request
o_dmem_we  out  1  write enable
o_dmem_addr  out  NB_BITS  word-aligned address ({addr[NB_BITS-1:2],2'b00})
o_dmem_wdata  out  NB_BITS  lane-replicated store data
o_dmem_be  out  4  byte enables
i_dmem_ack  in  1  access complete; rdata valid this cycle
i_dmem_rdata  in  NB_BITS  read data
o_stall  out  1  hold EX/MEM and earlier stages
o_valid  out  1  MEM/WB valid
o_mem_data  out  NB_BITS  aligned load data
o_alu_data  out  NB_BITS  registered ALU result
o_mux_mem_to_reg  out  2  write-back select
o_reg_write  out  1  registered write enable (gated by o_valid)
o_rd_addr  out  NB_REG  registered destination
o_misaligned  out  1  one-cycle pulse: misaligned access
o_bus_error  out  1  one-cycle pulse: ack timeout

Behaviour:
- Reset (i_reset=0, async): state IDLE, timeout counter 0, and every output 0.
- Reset mid-access: o_dmem_req drops immediately and no write-back occurs.
- FSM has two states: IDLE and WAIT.
- IDLE, no memory op (i_valid & ~(read|write)):
  - MEM/WB captures the inputs next edge, giving 1-cycle latency.
  - o_mux_mem_to_reg = i_mux_mem_to_reg.
  - o_stall=0.
- i_valid=0: o_valid=0 next cycle and o_reg_write=0.
- Alignment rules: half needs addr[0]=0; word needs addr[1:0]=0.
- IDLE, aligned memory op:
  - o_stall=1 combinationally in that cycle.
  - Request fields latched; go to WAIT.
  - o_dmem_req=1 from the next cycle.
- IDLE, misaligned memory op:
  - No request issued; o_misaligned pulses next cycle.
  - o_valid=1 with o_reg_write=0; no stall.
- WAIT:
  - o_dmem_req held with stable addr, we, wdata and be.
  - o_stall=1 until the ack cycle; o_stall=0 in the ack cycle.
- WAIT with i_dmem_ack=1:
  - MEM/WB loads next edge; o_dmem_req=0 next cycle; return to IDLE.
  - A new op presented in the ack cycle is not accepted until the following cycle, because EX/MEM advances on that edge.
- Timeout: the counter increments each WAIT cycle without ack. At TIMEOUT:
  - Drop req and return to IDLE.
  - o_bus_error pulses; o_valid=1, o_reg_write=0.
  - A late ack arriving in IDLE is ignored.
- Store lanes (little-endian, a=addr[1:0]):
  - Byte: wdata={4{d[7:0]}}, be=4'b0001<<a.
  - Half: wdata={2{d[15:0]}}, be = a[1] ? 4'b1100 : 4'b0011.
  - Word: be=4'b1111.
- Loads: be=4'b1111 and we=0. r = rdata >> (8*a).
  - Word: o_mem_data=r, code `DATA_FROM_MEM.
  - Byte unsigned: {24'b0,r[7:0]}, `DATA_FROM_MEM.
  - Byte signed: {24'b0,r[7:0]}, `DATA_SIGN_BYT.
  - Half unsigned: {16'b0,r[15:0]}, `DATA_FROM_MEM.
  - Half signed: {16'b0,r[15:0]}, `DATA_SIGN_HAL.
- Stores write no register: o_reg_write=0 regardless of i_reg_write.
- i_mem_read and i_mem_write both set: treated as a load.

Test Plan:
- Reset: hold i_reset=0 mid-WAIT → req=0 and all outputs 0 immediately; after release no spurious o_valid.
- ALU op, addr=0x1234, rd=5, code `DATA_FROM_ALU → next cycle o_valid=1, o_alu_data=0x1234, o_rd_addr=5, no stall.
- LB at 0x103, memory acks after 3 cycles with rdata=0x80AABBCC → stall for 4 cycles; o_mem_data=0x00000080 with `DATA_SIGN_BYT. Same access as LBU → 0x00000080 with `DATA_FROM_MEM.
- SH at 0x202, store_data=0x0000BEEF, immediate ack → addr=0x200, wdata=0xBEEFBEEF, be=1100, we=1; o_reg_write=0.
- LW at 0x101 → no req, o_misaligned pulse, o_reg_write=0, no stall.
- Load with no ack, TIMEOUT=16 → req high for exactly 16 cycles; o_bus_error pulse; FSM back in IDLE; next ALU op passes normally.
